// File: rtl/bus_slave_sel_pkg.sv
// Shared definitions for the bus slave selector: FSM states,
// default geometry/timeout values and the decode range helper.
package bus_slave_sel_pkg;

   localparam int SLAVE_NUM_DEF = 8;
   localparam int ADDR_W_DEF    = 30;
   localparam int SEL_W_DEF     = 3;
   localparam int TIMEOUT_DEF   = 255;
   localparam int CNT_W_DEF     = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

   // True when a decoded index maps onto a populated slave.
   function automatic logic idx_ok(input int idx, input int n);
      return idx < n;
   endfunction

endpackage

// File: rtl/bus_slave_sel_if.sv
// Master/slave bus bundle of the slave selector.
// master: drives m_as_, m_addr, s_rdy_; slave: drives the rest.
interface bus_slave_sel_if #(
   parameter int SLAVE_NUM = 8,
   parameter int ADDR_W    = 30,
   parameter int SEL_W     = 3
);
   logic                 m_as_;
   logic [ADDR_W-1:0]    m_addr;
   logic [SLAVE_NUM-1:0] s_rdy_;
   logic [SLAVE_NUM-1:0] s_cs_;
   logic                 m_rdy_;
   logic                 m_err;
   logic                 busy;
   logic [SEL_W-1:0]     sel_idx;
   logic [ADDR_W-1:0]    err_addr;

   modport master (
      output m_as_, m_addr, s_rdy_,
      input  s_cs_, m_rdy_, m_err, busy, sel_idx, err_addr
   );

   modport slave (
      input  m_as_, m_addr, s_rdy_,
      output s_cs_, m_rdy_, m_err, busy, sel_idx, err_addr
   );
endinterface

// File: rtl/bus_tmo_cnt.sv
// Access timeout counter: clr, en, saturating count, terminal flag.
// Ports: clk, reset_, clr, en in; tc out (count == TIMEOUT-1).
module bus_tmo_cnt #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [CNT_W-1:0] cnt;

   assign tc = (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/bus_slave_sel.sv
// Address-decoding slave selector with per-access timeout.
// Ports: clk, reset_ (async low), bus (slave modport).
module bus_slave_sel
   import bus_slave_sel_pkg::*;
#(
   parameter int SLAVE_NUM = SLAVE_NUM_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int SEL_W     = SEL_W_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          reset_,
   bus_slave_sel_if.slave bus
);
   localparam logic [SLAVE_NUM-1:0] CS_ONE = SLAVE_NUM'(1);

   state_t               state;
   logic [SLAVE_NUM-1:0] cs_q;
   logic                 rdy_q;
   logic                 err_q;
   logic                 busy_q;
   logic [SEL_W-1:0]     sel_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [ADDR_W-1:0]    eaddr_q;

   logic [SEL_W-1:0] dec_idx;
   logic             dec_ok;
   logic             tc;

   assign dec_idx = bus.m_addr[ADDR_W-1 -: SEL_W];
   assign dec_ok  = idx_ok(32'(dec_idx), SLAVE_NUM);

   // Counter only runs inside ACCESS; any other state holds it at zero.
   bus_tmo_cnt #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk    (clk),
      .reset_ (reset_),
      .clr    (state != ACCESS),
      .en     (state == ACCESS),
      .tc     (tc)
   );

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state   <= IDLE;
         cs_q    <= '1;
         rdy_q   <= 1'b1;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         eaddr_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.m_as_) begin
                  busy_q <= 1'b1;
                  if (dec_ok) begin
                     state  <= ACCESS;
                     cs_q   <= ~(CS_ONE << dec_idx);
                     sel_q  <= dec_idx;
                     addr_q <= bus.m_addr;
                  end else begin
                     state   <= ERR;
                     eaddr_q <= bus.m_addr;
                     rdy_q   <= 1'b0;
                     err_q   <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // Ready is checked first so it wins over a timeout.
               if (!bus.s_rdy_[sel_q]) begin
                  state <= DONE;
                  cs_q  <= '1;
                  rdy_q <= 1'b0;
               end else if (tc) begin
                  state   <= ERR;
                  cs_q    <= '1;
                  rdy_q   <= 1'b0;
                  err_q   <= 1'b1;
                  eaddr_q <= addr_q;
               end
            end
            DONE, ERR: begin
               state  <= IDLE;
               rdy_q  <= 1'b1;
               err_q  <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.s_cs_    = cs_q;
   assign bus.m_rdy_   = rdy_q;
   assign bus.m_err    = err_q;
   assign bus.busy     = busy_q;
   assign bus.sel_idx  = sel_q;
   assign bus.err_addr = eaddr_q;
endmodule

// File: tb/tb_bus_slave_sel.sv
// Bench for bus_slave_sel: two instances (default and 6-slave/4-cycle
// timeout) checked every cycle against a transaction-level model.
module tb_bus_slave_sel;

   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   int ns[2] = '{8, 6};
   int to[2] = '{255, 4};

   logic        as_[2];
   logic [29:0] addr[2];
   logic [7:0]  rdy[2];

   // model: active access, selected slave, cycles spent, pending pulse
   int          act[2];
   int          sel[2];
   int          age[2];
   int          pulse[2];
   logic [29:0] cap[2];
   logic [29:0] eaddr[2];

   bus_slave_sel_if #(.SLAVE_NUM(8), .ADDR_W(30), .SEL_W(3)) bi0 ();
   bus_slave_sel_if #(.SLAVE_NUM(6), .ADDR_W(30), .SEL_W(3)) bi1 ();

   assign bi0.m_as_  = as_[0];
   assign bi0.m_addr = addr[0];
   assign bi0.s_rdy_ = rdy[0];
   assign bi1.m_as_  = as_[1];
   assign bi1.m_addr = addr[1];
   assign bi1.s_rdy_ = rdy[1][5:0];

   bus_slave_sel u0 (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bi0.slave)
   );

   bus_slave_sel #(
      .SLAVE_NUM (6),
      .TIMEOUT   (4)
   ) u1 (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bi1.slave)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int d = 0; d < 2; d++) begin
         act[d]   = 0;
         sel[d]   = 0;
         age[d]   = 0;
         pulse[d] = 0;
         cap[d]   = '0;
         eaddr[d] = '0;
      end
   endtask

   task automatic mdl_step(int d);
      int k;
      if (pulse[d] != 0) begin
         pulse[d] = 0;
      end else if (act[d] != 0) begin
         if (rdy[d][sel[d]] == 1'b0) begin
            act[d]   = 0;
            pulse[d] = 1;
         end else if (age[d] + 1 >= to[d]) begin
            act[d]   = 0;
            pulse[d] = 2;
            eaddr[d] = cap[d];
         end else begin
            age[d]++;
         end
      end else if (as_[d] == 1'b0) begin
         k = int'(addr[d] >> 27);
         if (k < ns[d]) begin
            act[d] = 1;
            sel[d] = k;
            age[d] = 0;
            cap[d] = addr[d];
         end else begin
            pulse[d] = 2;
            eaddr[d] = addr[d];
         end
      end
   endtask

   task automatic cmp(int d, logic [63:0] cs, logic r, logic e,
                      logic b, logic [63:0] s, logic [63:0] ea);
      logic [63:0] mask;
      logic [63:0] ecs;
      mask = (64'd1 << ns[d]) - 64'd1;
      ecs  = (act[d] != 0) ? (~(64'd1 << sel[d]) & mask) : mask;
      chk($sformatf("d%0d_cs", d), cs, ecs);
      chk($sformatf("d%0d_rdy", d), 64'(r), 64'(pulse[d] == 0));
      chk($sformatf("d%0d_err", d), 64'(e), 64'(pulse[d] == 2));
      chk($sformatf("d%0d_busy", d), 64'(b),
          64'((act[d] != 0) || (pulse[d] != 0)));
      chk($sformatf("d%0d_sel", d), s, 64'(sel[d]));
      chk($sformatf("d%0d_eaddr", d), ea, 64'(eaddr[d]));
      chk($sformatf("d%0d_onehot", d),
          64'($countones(~cs & mask) <= 1), 64'd1);
   endtask

   task automatic check_all();
      cmp(0, 64'(bi0.s_cs_), bi0.m_rdy_, bi0.m_err, bi0.busy,
          64'(bi0.sel_idx), 64'(bi0.err_addr));
      cmp(1, 64'(bi1.s_cs_), bi1.m_rdy_, bi1.m_err, bi1.busy,
          64'(bi1.sel_idx), 64'(bi1.err_addr));
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_) begin
         mdl_step(0);
         mdl_step(1);
      end else begin
         mdl_reset();
      end
      #1;
      check_all();
   endtask

   task automatic idle_in();
      as_[0]  = 1'b1;
      as_[1]  = 1'b1;
      rdy[0]  = 8'hFF;
      rdy[1]  = 8'hFF;
      addr[0] = '0;
      addr[1] = '0;
   endtask

   initial begin
      int low;
      idle_in();
      mdl_reset();
      reset_ = 1'b1;
      #1;
      reset_ = 1'b0;
      #1;
      check_all();
      tick();
      tick();
      reset_ = 1'b1;
      tick();

      // mapped access on default instance, unmapped on 6-slave one
      as_[0]  = 1'b0;
      addr[0] = 30'h0800_0000;
      as_[1]  = 1'b0;
      addr[1] = 30'h3800_0000;
      tick();
      chk("r035_cs", 64'(bi0.s_cs_), 64'h0FD);
      chk("r036_cs", 64'(bi1.s_cs_), 64'h03F);
      chk("r036_rdy", 64'(bi1.m_rdy_), 64'd0);
      chk("r036_err", 64'(bi1.m_err), 64'd1);
      chk("r036_eaddr", 64'(bi1.err_addr), 64'h3800_0000);
      as_[0] = 1'b1;
      as_[1] = 1'b1;
      rdy[0] = 8'hFD;
      tick();
      chk("r035_rdy", 64'(bi0.m_rdy_), 64'd0);
      chk("r035_err", 64'(bi0.m_err), 64'd0);
      chk("r035_cs_off", 64'(bi0.s_cs_), 64'h0FF);
      rdy[0] = 8'hFF;
      tick();

      // timeout on slave 2; address wiggled during ACCESS
      as_[1]  = 1'b0;
      addr[1] = 30'h1000_0000;
      tick();
      as_[1]  = 1'b1;
      addr[1] = 30'($urandom);
      low = (bi1.s_cs_ == 6'h3B) ? 1 : 0;
      repeat (4) begin
         tick();
         if (bi1.s_cs_ == 6'h3B) low++;
      end
      chk("r037_cs_cycles", 64'(low), 64'd4);
      chk("r037_rdy", 64'(bi1.m_rdy_), 64'd0);
      chk("r037_err", 64'(bi1.m_err), 64'd1);
      chk("r037_eaddr", 64'(bi1.err_addr), 64'h1000_0000);
      tick();
      chk("r037_busy", 64'(bi1.busy), 64'd0);

      // ready on the last allowed cycle, foreign ready ignored
      as_[1]  = 1'b0;
      addr[1] = 30'h1000_0000;
      rdy[1]  = 8'hDF;
      tick();
      as_[1] = 1'b1;
      repeat (3) tick();
      chk("r038_cs", 64'(bi1.s_cs_), 64'h03B);
      rdy[1] = 8'hDB;
      tick();
      chk("r038_rdy", 64'(bi1.m_rdy_), 64'd0);
      chk("r038_err", 64'(bi1.m_err), 64'd0);
      rdy[1] = 8'hFF;
      tick();

      // asynchronous reset in the middle of an access
      as_[0]  = 1'b0;
      addr[0] = 30'h1800_0000;
      tick();
      as_[0] = 1'b1;
      tick();
      chk("r039_pre_cs", 64'(bi0.s_cs_), 64'h0F7);
      #3;
      reset_ = 1'b0;
      mdl_reset();
      #1;
      check_all();
      chk("r039_cs", 64'(bi0.s_cs_), 64'h0FF);
      tick();
      chk("r039_rdy", 64'(bi0.m_rdy_), 64'd1);
      tick();
      reset_ = 1'b1;
      tick();

      // m_as_ held low with a slave that is always ready
      as_[0]  = 1'b0;
      addr[0] = 30'h1800_0000;
      rdy[0]  = 8'hF7;
      tick();
      chk("r040_cs1", 64'(bi0.s_cs_), 64'h0F7);
      tick();
      chk("r040_done", 64'(bi0.m_rdy_), 64'd0);
      tick();
      chk("r040_idle", 64'(bi0.busy), 64'd0);
      tick();
      chk("r040_cs2", 64'(bi0.s_cs_), 64'h0F7);
      repeat (3) tick();
      idle_in();
      tick();
      tick();

      // random traffic on both instances
      repeat (400) begin
         for (int d = 0; d < 2; d++) begin
            as_[d]  = 1'($urandom_range(0, 1));
            addr[d] = 30'($urandom);
            rdy[d]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
